// File: rtl/uart_ctrl_if.sv
// CPU bus interface of the UART peripheral: chip select, strobes, address,
// write data, combinational read data and the interrupt request.
interface uart_ctrl_if;
  logic        CS_N;
  logic        RD_N;
  logic        WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Intr;

  modport master (
    output CS_N, RD_N, WR_N, Addr, DataIn,
    input  DataOut, Intr
  );

  modport slave (
    input  CS_N, RD_N, WR_N, Addr, DataIn,
    output DataOut, Intr
  );
endinterface

// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART peripheral.
// TX path: TX_DEPTH-entry byte FIFO feeding a serial shift FSM.
// RX path: 2-flop synchronizer, mid-bit sampling FSM, single holding register.
// Register map (Addr[3:2]): 0 TXDATA, 1 RXDATA, 2 STATUS (W1C [6:3]), 3 CTRL.
// Optional feature: define UART_LOOPBACK_EN to add CTRL[2] LOOP, which routes
// the internal TX serial stream into the RX synchronizer and parks UART_TXD high.
module uart_ctrl #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int TX_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  uart_ctrl_if.slave bus,
  output logic       UART_TXD,
  input  logic       UART_RXD
);

  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF   = CW'(DIV / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

  // Bus decode
  logic       wr_en;
  logic [1:0] sel;
  logic       wr_tx;
  logic       wr_st;
  logic       wr_ctrl;

  assign wr_en   = ~bus.CS_N & ~bus.WR_N;
  assign sel     = bus.Addr[3:2];
  assign wr_tx   = wr_en & (sel == 2'd0);
  assign wr_st   = wr_en & (sel == 2'd2);
  assign wr_ctrl = wr_en & (sel == 2'd3);

  // Read strobe, upper data bits and undecoded address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{bus.RD_N, bus.Addr[11:4], bus.Addr[1:0], bus.DataIn[31:8]};

  // Control and status state
  logic tx_ie, rx_ie, loop_en;
  logic rx_valid, rx_ovr, rx_ferr, tx_drop;
  logic intr_q;

  // TX FIFO
  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty;
  logic          push, tx_pop, drop_set;

  assign fifo_full  = (count == (AW+1)'(TX_DEPTH));
  assign fifo_empty = (count == '0);
  // A pop on the same edge frees the slot, so a write to a full FIFO is kept
  assign push       = wr_tx & (~fifo_full | tx_pop);
  assign drop_set   = wr_tx & fifo_full & ~tx_pop;

  // FIFO storage: data only, no reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= bus.DataIn[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (tx_pop) rptr <= rptr + 1'b1;
      case ({push, tx_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // TX FSM
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_cnt_end;
  logic          tx_line, tx_busy;

  assign tx_cnt_end = (tx_cnt == DIV_M1);

  // TX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  // TX next state; STOP reloads straight into START when more bytes wait
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!fifo_empty) begin
                  tx_pop  = 1'b1;
                  tx_next = TX_START;
                end
      TX_START: if (tx_cnt_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_cnt_end && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_cnt_end) begin
                  if (!fifo_empty) begin
                    tx_pop  = 1'b1;
                    tx_next = TX_START;
                  end else begin
                    tx_next = TX_IDLE;
                  end
                end
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX outputs: serial level and busy flag
  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_shift[0];
      default:  tx_line = 1'b1;
    endcase
    tx_busy  = (tx_state != TX_IDLE);
    UART_TXD = tx_line | loop_en;
  end

  // TX bit timer and bit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_cnt <= '0;
      tx_idx <= '0;
    end else begin
      if (tx_state == TX_IDLE || tx_cnt_end) tx_cnt <= '0;
      else                                   tx_cnt <= tx_cnt + 1'b1;
      if (tx_state != TX_DATA) tx_idx <= '0;
      else if (tx_cnt_end)     tx_idx <= tx_idx + 1'b1;
    end
  end

  // TX shift register: load on pop, shift LSB-first after each data bit
  always_ff @(posedge clk) begin
    if (tx_pop)                            tx_shift <= fifo_mem[rptr];
    else if (tx_state == TX_DATA && tx_cnt_end) tx_shift <= {1'b0, tx_shift[7:1]};
  end

  // RX input synchronizer; idles high so reset never looks like a start bit
  logic rx_in, rx_meta, rxs;
  assign rx_in = loop_en ? tx_line : UART_RXD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  // RX FSM
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_byte;
  logic          rx_zero, rx_sample, rx_done, ferr_set;

  assign rx_zero = (rx_cnt == '0);

  // RX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  // RX next state; a start bit that is high again at mid-bit is a glitch
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (!rxs) rx_next = RX_START;
      RX_START:  if (rx_zero) rx_next = rxs ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_zero && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:   if (rx_zero) rx_next = rxs ? RX_IDLE : RX_WAITHI;
      RX_WAITHI: if (rxs) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  // RX sampling strobes
  always_comb begin
    rx_sample = (rx_state == RX_DATA) && rx_zero;
    rx_done   = (rx_state == RX_STOP) && rx_zero && rxs;
    ferr_set  = (rx_state == RX_STOP) && rx_zero && !rxs;
  end

  // RX bit timer: half a bit to mid-start, then a full bit per sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt <= '0;
      rx_idx <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_state == RX_WAITHI) rx_cnt <= HALF;
      else if (rx_zero)                                 rx_cnt <= DIV_M1;
      else                                              rx_cnt <= rx_cnt - 1'b1;
      if (rx_state != RX_DATA) rx_idx <= '0;
      else if (rx_zero)        rx_idx <= rx_idx + 1'b1;
    end
  end

  // RX data path: LSB-first shift and holding register
  always_ff @(posedge clk) begin
    if (rx_sample) rx_shift <= {rxs, rx_shift[7:1]};
    if (rx_done)   rx_byte  <= rx_shift;
  end

  // Sticky status flags; a hardware set outranks a same-edge W1C
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
      tx_drop  <= 1'b0;
    end else begin
      rx_valid <= rx_done              | (rx_valid & ~(wr_st & bus.DataIn[3]));
      rx_ovr   <= (rx_done & rx_valid) | (rx_ovr   & ~(wr_st & bus.DataIn[4]));
      rx_ferr  <= ferr_set             | (rx_ferr  & ~(wr_st & bus.DataIn[5]));
      tx_drop  <= drop_set             | (tx_drop  & ~(wr_st & bus.DataIn[6]));
    end
  end

  // Control register
`ifdef UART_LOOPBACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ie   <= 1'b0;
      rx_ie   <= 1'b0;
      loop_en <= 1'b0;
    end else if (wr_ctrl) begin
      tx_ie   <= bus.DataIn[0];
      rx_ie   <= bus.DataIn[1];
      loop_en <= bus.DataIn[2];
    end
  end
`else
  assign loop_en = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ie <= 1'b0;
      rx_ie <= 1'b0;
    end else if (wr_ctrl) begin
      tx_ie <= bus.DataIn[0];
      rx_ie <= bus.DataIn[1];
    end
  end
`endif

  // Registered level interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) intr_q <= 1'b0;
    else       intr_q <= (rx_ie & rx_valid) | (tx_ie & fifo_empty & ~tx_busy);
  end

  assign bus.Intr = intr_q;

  // Combinational read mux
  always_comb begin
    bus.DataOut = '0;
    case (sel)
      2'd1:    bus.DataOut = {24'b0, rx_byte};
      2'd2:    bus.DataOut = {25'b0, tx_drop, rx_ferr, rx_ovr, rx_valid,
                              tx_busy, fifo_empty, fifo_full};
      2'd3:    bus.DataOut = {29'b0, loop_en, rx_ie, tx_ie};
      default: bus.DataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: register checks inline, TX bytes checked by a
// serial-line monitor against a queue of expected bytes.
module tb_uart_ctrl;
  localparam int DIV   = 50_000_000 / 115_200;
  localparam int FRAME = 10 * DIV;

  logic clk = 1'b0;
  logic reset;
  logic UART_TXD;
  logic UART_RXD;
  int   cyc = 0;

  uart_ctrl_if bus ();

  uart_ctrl #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(115_200), .TX_DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .UART_TXD (UART_TXD),
    .UART_RXD (UART_RXD)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         start_cyc[$];
  bit         mon_ignore = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.Addr = a;
    #1;
    check(name, bus.DataOut, exp);
  endtask

  // Call just after a falling edge; returns at the next falling edge
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.Addr   = a;
    bus.DataIn = d;
    bus.CS_N   = 1'b0;
    bus.WR_N   = 1'b0;
    @(negedge clk);
    bus.CS_N   = 1'b1;
    bus.WR_N   = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    UART_RXD = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = b[i];
      repeat (DIV) @(negedge clk);
    end
    UART_RXD = stopb;
    repeat (DIV) @(negedge clk);
    UART_RXD = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_q_empty(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL tx_drain: %0d bytes pending after %0d cycles, expected 0", exp_q.size(), budget);
    end
    repeat (DIV) @(negedge clk);
  endtask

  // Serial monitor: decode each TX frame at mid-bit and score it
  initial begin : tx_monitor
    logic [7:0] b;
    logic       stopb;
    logic       startb;
    bit         ign;
    forever begin
      @(negedge clk);
      if (UART_TXD === 1'b0 && reset === 1'b0) begin
        ign = mon_ignore;
        if (!ign) start_cyc.push_back(cyc);
        repeat (DIV / 2) @(negedge clk);
        startb = UART_TXD;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = UART_TXD;
        end
        repeat (DIV) @(negedge clk);
        stopb = UART_TXD;
        if (!ign) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL tx_frame: unexpected byte 0x%02h, expected no frame", b);
          end else begin
            check("tx_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
            check("tx_start_bit", {31'b0, startb}, 32'h0);
            check("tx_stop_bit", {31'b0, stopb}, 32'h1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(150_000 * 10);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int bad_hi;
    bus.CS_N   = 1'b1;
    bus.RD_N   = 1'b1;
    bus.WR_N   = 1'b1;
    bus.Addr   = '0;
    bus.DataIn = '0;
    UART_RXD   = 1'b1;
    reset      = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_txd", {31'b0, UART_TXD}, 32'h1);
    check("rst_intr", {31'b0, bus.Intr}, 32'h0);
    check_reg("rst_status", 12'h8, 32'h02);
    check_reg("rst_ctrl", 12'hC, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reg("idle_status", 12'h8, 32'h02);

    // Single byte 0x55: start bit one edge after the write edge, 10 bits total
    exp_q.push_back(8'h55);
    wr(12'h0, 32'h55);
    check("tx55_before_start", {31'b0, UART_TXD}, 32'h1);
    @(negedge clk);
    check("tx55_start", {31'b0, UART_TXD}, 32'h0);
    check_reg("tx55_busy", 12'h8, 32'h06);
    repeat (FRAME - 1) @(negedge clk);
    check_reg("tx55_last_busy", 12'h8, 32'h06);
    @(negedge clk);
    check_reg("tx55_done", 12'h8, 32'h02);
    check("tx55_queue", exp_q.size(), 32'h0);

    // Overflow: 0x11 occupies the shifter, then 9 writes into an 8-deep FIFO
    start_cyc.delete();
    exp_q.push_back(8'h11);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'hA0 + 8'(i));
    wr(12'h0, 32'h11);
    for (int i = 0; i < 9; i++) wr(12'h0, 32'hA0 + i);
    check_reg("ovf_status", 12'h8, 32'h45);
    wr(12'h8, 32'h40);
    check_reg("ovf_drop_clr", 12'h8, 32'h05);
    wait_q_empty(10 * FRAME);
    check("ovf_frames", start_cyc.size(), 32'd9);
    for (int i = 1; i < 9 && i < start_cyc.size(); i++)
      check("ovf_no_gap", start_cyc[i] - start_cyc[i-1], FRAME);
    check_reg("ovf_idle", 12'h8, 32'h02);

    // RX frame, interrupt enable, overrun
    send_frame(8'hA3, 1'b1);
    check_reg("rx_a3_data", 12'h4, 32'hA3);
    check_reg("rx_a3_status", 12'h8, 32'h0A);
    check("rx_intr_off", {31'b0, bus.Intr}, 32'h0);
    wr(12'hC, 32'h2);
    @(negedge clk);
    check("rx_intr_on", {31'b0, bus.Intr}, 32'h1);
    send_frame(8'h3C, 1'b1);
    check_reg("rx_ovr_status", 12'h8, 32'h1A);
    check_reg("rx_ovr_data", 12'h4, 32'h3C);
    wr(12'h8, 32'h10);
    check_reg("rx_ovr_clr", 12'h8, 32'h0A);

    // Framing error keeps the held byte and RX_VALID
    send_frame(8'h5A, 1'b0);
    check_reg("ferr_status", 12'h8, 32'h2A);
    check_reg("ferr_data", 12'h4, 32'h3C);
    wr(12'h8, 32'h78);
    @(negedge clk);
    check_reg("w1c_all", 12'h8, 32'h02);
    check("rx_intr_cleared", {31'b0, bus.Intr}, 32'h0);

    // TX-empty interrupt
    wr(12'hC, 32'h1);
    @(negedge clk);
    check("tx_intr_on", {31'b0, bus.Intr}, 32'h1);
    wr(12'hC, 32'h0);
    @(negedge clk);
    check("tx_intr_off", {31'b0, bus.Intr}, 32'h0);

    // 100-cycle low glitch is rejected
    UART_RXD = 1'b0;
    repeat (100) @(negedge clk);
    UART_RXD = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check_reg("glitch_status", 12'h8, 32'h02);
    check_reg("glitch_data", 12'h4, 32'h3C);

`ifdef UART_LOOPBACK_EN
    wr(12'hC, 32'h4);
    check_reg("loop_ctrl", 12'hC, 32'h4);
    wr(12'h0, 32'h7E);
    bad_hi = 0;
    for (int i = 0; i < FRAME + DIV; i++) begin
      @(negedge clk);
      if (UART_TXD !== 1'b1) bad_hi++;
    end
    check("loop_txd_low_cycles", bad_hi, 32'h0);
    check_reg("loop_data", 12'h4, 32'h7E);
    check_reg("loop_status", 12'h8, 32'h0A);
    wr(12'hC, 32'h0);
    wr(12'h8, 32'h78);
`else
    bad_hi = 0;
    wr(12'hC, 32'h7);
    check_reg("ctrl_no_loop", 12'hC, 32'h3);
    wr(12'hC, 32'h0);
`endif

    // Reset mid-frame aborts TX and forces the line high at once
    mon_ignore = 1'b1;
    wr(12'hC, 32'h3);
    wr(12'h0, 32'h99);
    repeat (1000) @(negedge clk);
    check_reg("midframe_busy", 12'h8, 32'h06);
    reset = 1'b1;
    #1;
    check("midframe_txd", {31'b0, UART_TXD}, 32'h1);
    check("midframe_intr", {31'b0, bus.Intr}, 32'h0);
    check_reg("midframe_status", 12'h8, 32'h02);
    check_reg("midframe_ctrl", 12'hC, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bad_hi = 0;
    for (int i = 0; i < FRAME + DIV; i++) begin
      @(negedge clk);
      if (UART_TXD !== 1'b1) bad_hi++;
    end
    check("post_reset_txd_low_cycles", bad_hi, 32'h0);
    check_reg("post_reset_status", 12'h8, 32'h02);
    mon_ignore = 1'b0;
    check("final_queue", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
